// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding and note-word field layout for the note sequencer
package note_seq_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, GAP, NEXT} state_t;
  localparam int NOTE_W = 8;
  localparam int DUR_W = 8;
  localparam int WORD_W = NOTE_W + DUR_W;
  localparam int NOTE_LSB = 0;
  localparam int DUR_LSB = 8;
  function automatic logic [NOTE_W-1:0] note_of(input logic [WORD_W-1:0] w);
    return w[NOTE_LSB +: NOTE_W];
  endfunction
  function automatic logic [DUR_W-1:0] dur_of(input logic [WORD_W-1:0] w);
    return w[DUR_LSB +: DUR_W];
  endfunction
endpackage

// File: rtl/note_fifo.sv
// note_fifo: DEPTH x W register FIFO with flush, sticky overflow and head word read from the register array
module note_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_pop = pop && !empty && !flush;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign do_push = push && !flush && (!full || do_pop);
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      ovf <= 1'b0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      ovf <= 1'b0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      level <= level + LW'(do_push) - LW'(do_pop);
      ovf <= ovf || (push && !do_push);
    end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays queued (note, duration) words onto the beep mode input with a silent gap after each note
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TICK_DIV = 6250000,
  parameter int GAP_CYC = 625000
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     wr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     clr,
  output logic [NOTE_W-1:0]        mode_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     busy,
  output logic                     ovf,
  output logic                     done
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  state_t state;
  logic [TW-1:0] tick;
  logic [GW-1:0] gcnt;
  logic [DUR_W-1:0] dur;
  logic [NOTE_W-1:0] note;
  logic [WORD_W-1:0] head;
  logic pop;
  logic [DUR_W-1:0] hdur;
  assign hdur = dur_of(head);
  assign pop = !clr && !empty && (state == IDLE || state == NEXT);
  assign busy = state != IDLE;
  note_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk(clk), .reset_(reset_), .push(wr), .pop(pop), .flush(clr), .din(wdata),
    .head(head), .level(level), .full(full), .empty(empty), .ovf(ovf)
  );
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      state <= IDLE;
      mode_out <= '0;
      done <= 1'b0;
      tick <= '0;
      gcnt <= '0;
      dur <= '0;
      note <= '0;
    end else if (clr) begin
      state <= IDLE;
      mode_out <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, NEXT:
          if (!empty) begin
            note <= note_of(head);
            dur <= hdur;
            tick <= '0;
            // a zero-duration entry is consumed without ever reaching PLAY
            state <= hdur == '0 ? NEXT : PLAY;
            mode_out <= hdur == '0 ? '0 : note_of(head);
          end else begin
            state <= IDLE;
            mode_out <= '0;
            done <= state == NEXT;
          end
        PLAY:
          if (tick == TW'(TICK_DIV - 1)) begin
            tick <= '0;
            dur <= dur - 1'b1;
            if (dur == DUR_W'(1)) begin
              mode_out <= '0;
              gcnt <= '0;
              state <= (note != '0 && GAP_CYC > 0) ? GAP : NEXT;
            end
          end else
            tick <= tick + 1'b1;
        GAP:
          if (gcnt == GW'(GAP_CYC - 1)) state <= NEXT;
          else gcnt <= gcnt + 1'b1;
      endcase
    end
endmodule
